nic_bus_cycle: RTL and testbench

Bus-cycle sequencer between the cartridge address decoder and the Ethernet controller (NIC) on the Falcon cartridge port. It consumes the decoder's registered active-low chip enable, which asserts for the 0xF1xxxx window while AS is low. It then generates NIC address, read/write strobes with programmable setup/strobe/hold timing, and a read-data latch, and returns DTACK to the 68030. It holds the acknowledged cycle until the CPU negates AS.

---
 rtl/nic_bus_cycle.sv | 177 +++++++++++++++++
 tb/tb_nic_bus_cycle.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/nic_bus_cycle.sv
// nic_bus_cycle: NIC bus-cycle sequencer on the Falcon cartridge port.
// Optional macro NIC_RDY_EN: stretch the strobe on NIC_RDY, with timeout flag TMO.
module nic_bus_cycle #(
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 3,
    parameter int HOLD_CYC   = 1,
    parameter int DATA_W     = 16,
    parameter int RDY_TMO    = 64
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              CE,
    input  logic              AS,
    input  logic              RW,
    input  logic [4:0]        A,
    input  logic [DATA_W-1:0] NIC_DIN,
    input  logic              NIC_RDY,
    output logic [4:0]        NIC_A,
    output logic              IOR_N,
    output logic              IOW_N,
    output logic [DATA_W-1:0] DOUT,
    output logic              DOE,
    output logic              DTACK_N,
    output logic              TMO
);

    localparam int MAX_A = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
    localparam int MAX_B = (HOLD_CYC > RDY_TMO) ? HOLD_CYC : RDY_TMO;
    localparam int MAX_V = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW    = $clog2(MAX_V + 1);

    localparam logic [CW-1:0] LD_SETUP  = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] LD_STROBE = CW'(STROBE_CYC - 1);
    localparam logic [CW-1:0] LD_HOLD   = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] LD_TMO    = CW'(RDY_TMO - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        ACK
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          rd;
    logic          strobe_done;
    logic          stretch_start;

`ifdef NIC_RDY_EN
    logic stretch;
    logic tmo_hit;
    logic tmo_q;

    // Decide strobe exit: normal at count 0 with NIC ready, else stretch until ready or timeout
    always_comb begin
        strobe_done   = 1'b0;
        stretch_start = 1'b0;
        tmo_hit       = 1'b0;
        if (!stretch) begin
            if (cnt == '0) begin
                if (NIC_RDY) strobe_done = 1'b1;
                else stretch_start = 1'b1;
            end
        end else begin
            if (NIC_RDY) begin
                strobe_done = 1'b1;
            end else if (cnt == '0) begin
                strobe_done = 1'b1;
                tmo_hit     = 1'b1;
            end
        end
    end

    // Stretch phase tracking and sticky timeout flag
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            stretch <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            if (state == STROBE && !AS && stretch_start)
                stretch <= 1'b1;
            else if (state != STROBE || AS || strobe_done)
                stretch <= 1'b0;
            if (state == STROBE && !AS && tmo_hit)
                tmo_q <= 1'b1;
        end
    end

    assign TMO = tmo_q;
`else
    logic unused_rdy;
    assign unused_rdy    = NIC_RDY;
    assign strobe_done   = (cnt == '0);
    assign stretch_start = 1'b0;
    assign TMO           = 1'b0;
`endif

    // Bus-cycle sequencer: address setup, strobe, hold, then acknowledge until AS negates
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state   <= IDLE;
            cnt     <= '0;
            rd      <= 1'b0;
            NIC_A   <= '0;
            IOR_N   <= 1'b1;
            IOW_N   <= 1'b1;
            DOUT    <= '0;
            DOE     <= 1'b0;
            DTACK_N <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!CE && !AS) begin
                        NIC_A <= A;
                        rd    <= RW;
                        cnt   <= LD_SETUP;
                        state <= SETUP;
                    end
                end
                SETUP: begin
                    if (AS) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else if (cnt == '0) begin
                        IOR_N <= ~rd;
                        IOW_N <= rd;
                        cnt   <= LD_STROBE;
                        state <= STROBE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                STROBE: begin
                    if (AS) begin
                        IOR_N <= 1'b1;
                        IOW_N <= 1'b1;
                        cnt   <= '0;
                        state <= IDLE;
                    end else if (strobe_done) begin
                        IOR_N <= 1'b1;
                        IOW_N <= 1'b1;
                        if (rd) DOUT <= NIC_DIN;
                        cnt   <= LD_HOLD;
                        state <= HOLD;
                    end else if (stretch_start) begin
                        cnt <= LD_TMO;
                    end else if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end
                end
                HOLD: begin
                    if (AS) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else if (cnt == '0) begin
                        DTACK_N <= 1'b0;
                        DOE     <= rd;
                        state   <= ACK;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ACK: begin
                    if (AS) begin
                        DTACK_N <= 1'b1;
                        DOE     <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nic_bus_cycle.sv
// tb_nic_bus_cycle: directed self-checking bench for nic_bus_cycle.
// Covers read, write, abort, async reset, back-to-back and NIC_RDY handling.
module tb_nic_bus_cycle;

    logic        CLK;
    logic        RESET;
    logic        CE;
    logic        AS;
    logic        RW;
    logic [4:0]  A;
    logic [15:0] NIC_DIN;
    logic        NIC_RDY;
    logic [4:0]  NIC_A;
    logic        IOR_N;
    logic        IOW_N;
    logic [15:0] DOUT;
    logic        DOE;
    logic        DTACK_N;
    logic        TMO;

    int n_checks = 0;
    int n_errors = 0;

    nic_bus_cycle dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .CE      (CE),
        .AS      (AS),
        .RW      (RW),
        .A       (A),
        .NIC_DIN (NIC_DIN),
        .NIC_RDY (NIC_RDY),
        .NIC_A   (NIC_A),
        .IOR_N   (IOR_N),
        .IOW_N   (IOW_N),
        .DOUT    (DOUT),
        .DOE     (DOE),
        .DTACK_N (DTACK_N),
        .TMO     (TMO)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Strobes must never be low together
    always @(negedge CLK)
        if (!RESET) check("strobe_excl", 32'(IOR_N | IOW_N), 32'd1);

    // Edge k=0 samples CE=0; strobe low after edges 1..slen; DTACK after slen+2.
    // NIC_RDY is first sampled high at edge rdy_edge.
    task automatic do_cycle(input logic rw, input logic [4:0] a,
                            input logic [15:0] din, input int slen,
                            input int rdy_edge, input logic [15:0] exp_dout);
        int  last;
        logic in_s;
        RW      = rw;
        A       = a;
        NIC_DIN = din;
        NIC_RDY = (rdy_edge <= 0);
        CE      = 1'b0;
        AS      = 1'b0;
        last    = slen + 2;
        for (int k = 0; k <= last; k++) begin
            tick();
            NIC_RDY = (k + 1 >= rdy_edge);
            in_s = (k >= 1) && (k <= slen);
            if (k == 0) check("nic_a", 32'(NIC_A), 32'(a));
            check("ior_n", 32'(IOR_N), 32'(!(rw && in_s)));
            check("iow_n", 32'(IOW_N), 32'(!(!rw && in_s)));
            check("dtack_n", 32'(DTACK_N), 32'(k != last));
            check("doe", 32'(DOE), 32'(rw && k == last));
        end
        check("dout", 32'(DOUT), 32'(exp_dout));
        tick();
        check("ack_hold", 32'(DTACK_N), 32'd0);
        check("ack_nic_a", 32'(NIC_A), 32'(a));
        NIC_RDY = 1'b1;
    endtask

    task automatic release_as();
        AS = 1'b1;
        CE = 1'b1;
        tick();
        check("rel_dtack_n", 32'(DTACK_N), 32'd1);
        check("rel_doe", 32'(DOE), 32'd0);
    endtask

    initial begin
        RESET   = 1'b1;
        CE      = 1'b1;
        AS      = 1'b1;
        RW      = 1'b1;
        A       = 5'h00;
        NIC_DIN = 16'h0000;
        NIC_RDY = 1'b1;
        #22;
        check("rst_nic_a", 32'(NIC_A), 32'd0);
        check("rst_ior_n", 32'(IOR_N), 32'd1);
        check("rst_iow_n", 32'(IOW_N), 32'd1);
        check("rst_dout", 32'(DOUT), 32'd0);
        check("rst_doe", 32'(DOE), 32'd0);
        check("rst_dtack_n", 32'(DTACK_N), 32'd1);
        check("rst_tmo", 32'(TMO), 32'd0);
        RESET = 1'b0;
        tick();

        // Read
        do_cycle(1'b1, 5'h0A, 16'hBEEF, 3, 0, 16'hBEEF);
        release_as();

        // Write: DOUT keeps the last read data
        do_cycle(1'b0, 5'h10, 16'h1234, 3, 0, 16'hBEEF);
        release_as();

        // Abort one cycle into STROBE
        RW = 1'b1; A = 5'h03; NIC_DIN = 16'h5555; CE = 1'b0; AS = 1'b0;
        tick();
        tick();
        check("abt_ior_low", 32'(IOR_N), 32'd0);
        AS = 1'b1; CE = 1'b1;
        tick();
        check("abt_ior_n", 32'(IOR_N), 32'd1);
        check("abt_iow_n", 32'(IOW_N), 32'd1);
        for (int i = 0; i < 4; i++) begin
            check("abt_dtack_n", 32'(DTACK_N), 32'd1);
            check("abt_dout", 32'(DOUT), 32'hBEEF);
            tick();
        end

`ifdef NIC_RDY_EN
        do_cycle(1'b1, 5'h05, 16'hA5A5, 8, 9, 16'hA5A5);
        check("tmo_stretch", 32'(TMO), 32'd0);
        release_as();
        do_cycle(1'b1, 5'h06, 16'h0F0F, 67, 100000, 16'h0F0F);
        check("tmo_set", 32'(TMO), 32'd1);
        release_as();
        tick();
        check("tmo_sticky", 32'(TMO), 32'd1);
`else
        do_cycle(1'b1, 5'h05, 16'hA5A5, 3, 100000, 16'hA5A5);
        check("tmo_tied", 32'(TMO), 32'd0);
        release_as();
`endif

        // Asynchronous reset mid-strobe
        RW = 1'b1; A = 5'h07; NIC_DIN = 16'hCAFE; CE = 1'b0; AS = 1'b0;
        tick();
        tick();
        check("pre_rst_ior", 32'(IOR_N), 32'd0);
        #2;
        RESET = 1'b1;
        AS = 1'b1; CE = 1'b1;
        #1;
        check("arst_ior_n", 32'(IOR_N), 32'd1);
        check("arst_dtack_n", 32'(DTACK_N), 32'd1);
        check("arst_doe", 32'(DOE), 32'd0);
        check("arst_nic_a", 32'(NIC_A), 32'd0);
        check("arst_dout", 32'(DOUT), 32'd0);
        check("arst_tmo", 32'(TMO), 32'd0);
        #3;
        RESET = 1'b0;
        tick();

        // Fresh read after reset, then back-to-back write
        do_cycle(1'b1, 5'h07, 16'hCAFE, 3, 0, 16'hCAFE);
        A = 5'h1F; RW = 1'b0;
        tick();
        check("b2b_ignore_dtack", 32'(DTACK_N), 32'd0);
        check("b2b_ignore_nic_a", 32'(NIC_A), 32'h07);
        release_as();
        do_cycle(1'b0, 5'h1F, 16'h9999, 3, 0, 16'hCAFE);
        release_as();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
